// File: rtl/sha256_pkg.sv
// sha256_pkg: controller state encoding, round count and SHA-256 constants shared with datapath and K-ROM.
package sha256_pkg;
  localparam int ROUNDS_DEF = 64;
  typedef enum logic [2:0] {S_IDLE, S_WINIT, S_ROUND, S_ACC, S_DONE} state_t;
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] k_rom(input logic [5:0] i);
    return K[i];
  endfunction
endpackage

// File: rtl/sha256_round_ctr.sv
// sha256_round_ctr: round counter with clear, load, enable and terminal count at ROUNDS-1.
module sha256_round_ctr #(
  parameter int CNT_W = 6,
  parameter int ROUNDS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] d,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (ld) cnt <= d;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == CNT_W'(ROUNDS - 1);
endmodule

// File: rtl/sha256_ctrl.sv
// sha256_ctrl: sequences init, schedule load, 64 rounds and hash accumulate per 512-bit block.
module sha256_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  input  logic             blk_last,
  output logic             blk_ready,
  output logic             msg_load,
  output logic             hash_init,
  output logic             wv_init,
  output logic             round_en,
  output logic [CNT_W-1:0] round_idx,
  output logic             hash_acc,
  output logic             digest_valid,
  input  logic             digest_ready
);
  state_t state, state_n;
  logic first_q, last_q, accept, tc;
  logic [CNT_W-1:0] cnt;
  assign accept = blk_valid & blk_ready;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      first_q <= 1'b1;
      last_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        last_q <= blk_last;
        first_q <= 1'b0;
      end else if (digest_valid && digest_ready) first_q <= 1'b1;
    end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = accept ? S_WINIT : S_IDLE;
      S_WINIT: state_n = S_ROUND;
      S_ROUND: state_n = tc ? S_ACC : S_ROUND;
      S_ACC:   state_n = last_q ? S_DONE : S_IDLE;
      S_DONE:  state_n = digest_ready ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  assign blk_ready = state == S_IDLE;
  assign msg_load = accept;
  assign hash_init = accept & first_q;
  assign wv_init = state == S_WINIT;
  assign round_en = state == S_ROUND;
  assign hash_acc = state == S_ACC;
  assign digest_valid = state == S_DONE;
  assign round_idx = round_en ? cnt : '0;
  // counter only moves in ROUND and is cleared on exit, so it is 0 on every ROUND entry
  sha256_round_ctr #(.CNT_W(CNT_W), .ROUNDS(ROUNDS)) u_ctr (
    .clk(clk),
    .rst(rst),
    .clr(round_en & tc),
    .ld(1'b0),
    .d('0),
    .en(round_en),
    .cnt(cnt),
    .tc(tc)
  );
endmodule

// File: tb/tb_sha256_ctrl.sv
// tb_sha256_ctrl: block-phase model of the controller checked every cycle, plus directed latency checks.
module tb_sha256_ctrl;
  logic clk = 0, rst, blk_valid, blk_last, digest_ready;
  logic blk_ready, msg_load, hash_init, wv_init, round_en, hash_acc, digest_valid;
  logic [5:0] round_idx;
  int compared = 0, mismatched = 0, acc_count = 0;
  bit mon_en = 0;
  bit m_busy = 0, m_done = 0, m_first = 1, m_last = 0;
  int m_k = 0;
  always #5 clk = ~clk;
  sha256_ctrl dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_last(blk_last),
    .blk_ready(blk_ready), .msg_load(msg_load), .hash_init(hash_init),
    .wv_init(wv_init), .round_en(round_en), .round_idx(round_idx),
    .hash_acc(hash_acc), .digest_valid(digest_valid), .digest_ready(digest_ready)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic bit e_ready();
    return !m_busy && !m_done;
  endfunction
  // model: a block occupies cycles k=1..66 after accept (1 winit, 2..65 rounds, 66 acc)
  always @(posedge clk) begin
    bit acc;
    acc = blk_valid && e_ready();
    if (rst) begin
      m_busy = 0; m_done = 0; m_first = 1; m_last = 0;
    end else if (acc) begin
      m_busy = 1; m_k = 1; m_last = blk_last; m_first = 0;
    end else if (m_busy) begin
      if (m_k == 66) begin
        m_busy = 0; m_done = m_last;
      end else m_k++;
    end else if (m_done && digest_ready) begin
      m_done = 0; m_first = 1;
    end
  end
  always @(negedge clk) if (mon_en) begin
    bit rd, re;
    rd = e_ready();
    re = m_busy && m_k >= 2 && m_k <= 65;
    check("blk_ready", blk_ready, rd);
    check("msg_load", msg_load, blk_valid & rd);
    check("hash_init", hash_init, blk_valid & rd & m_first);
    check("wv_init", wv_init, m_busy && m_k == 1);
    check("round_en", round_en, re);
    check("round_idx", round_idx, re ? m_k - 2 : 0);
    check("hash_acc", hash_acc, m_busy && m_k == 66);
    check("digest_valid", digest_valid, m_done);
    if (hash_acc) acc_count++;
  end
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, loads, snap;
    rst = 1; blk_valid = 1; blk_last = 1; digest_ready = 1;
    nxt();
    mon_en = 1;
    repeat (2) nxt();
    rst = 0; blk_valid = 0; digest_ready = 0;
    check("rst_blk_ready", blk_ready, 1);
    check("rst_digest_valid", digest_valid, 0);
    check("rst_round_en", round_en, 0);
    // single-block message
    blk_valid = 1; blk_last = 1;
    @(negedge clk);
    check("single_msg_load", msg_load, 1);
    check("single_hash_init", hash_init, 1);
    nxt(); blk_valid = 0;
    check("single_wv_init", wv_init, 1);
    n = 1;
    while (!digest_valid && n < 200) begin nxt(); n++; end
    check("single_latency", n, 67);
    repeat (10) nxt();
    check("bp_digest_valid", digest_valid, 1);
    check("bp_blk_ready", blk_ready, 0);
    digest_ready = 1; nxt(); digest_ready = 0;
    check("bp_release_ready", blk_ready, 1);
    // two-block message
    blk_valid = 1; blk_last = 0;
    @(negedge clk);
    check("two_first_hash_init", hash_init, 1);
    nxt(); blk_valid = 0;
    n = 1;
    while (!blk_ready && n < 200) begin nxt(); n++; end
    check("two_block1_latency", n, 67);
    blk_valid = 1; blk_last = 1;
    @(negedge clk);
    check("two_second_msg_load", msg_load, 1);
    check("two_second_hash_init", hash_init, 0);
    nxt(); blk_valid = 0;
    n = 1;
    while (!digest_valid && n < 200) begin nxt(); n++; end
    check("two_block2_latency", n, 67);
    digest_ready = 1; nxt(); digest_ready = 0;
    // blk_valid held high across four chained blocks
    blk_valid = 1; blk_last = 0; loads = 0;
    for (int i = 0; i < 268; i++) begin
      @(negedge clk);
      if (msg_load) loads++;
      nxt();
    end
    blk_valid = 0;
    check("held_valid_loads", loads, 4);
    // reset in the middle of rounds
    blk_valid = 1; blk_last = 1; nxt(); blk_valid = 0;
    n = 0;
    while (!(round_en && round_idx == 30) && n < 200) begin nxt(); n++; end
    check("abort_round_idx", round_idx, 30);
    snap = acc_count;
    rst = 1; nxt(); rst = 0;
    check("abort_blk_ready", blk_ready, 1);
    check("abort_round_en", round_en, 0);
    repeat (80) nxt();
    check("abort_no_hash_acc", acc_count, snap);
    blk_valid = 1;
    @(negedge clk);
    check("abort_next_hash_init", hash_init, 1);
    nxt(); blk_valid = 0;
    // reset and valid together while a block is in flight
    repeat (5) nxt();
    rst = 1; blk_valid = 1; nxt(); rst = 0; blk_valid = 0;
    check("rstv_blk_ready", blk_ready, 1);
    check("rstv_wv_init", wv_init, 0);
    blk_valid = 1;
    @(negedge clk);
    check("rstv_hash_init", hash_init, 1);
    nxt(); blk_valid = 0;
    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      blk_valid = $urandom_range(0, 3) == 0;
      blk_last = $urandom_range(0, 1) == 1;
      digest_ready = $urandom_range(0, 2) == 0;
      nxt();
    end
    rst = 0; blk_valid = 0; digest_ready = 0;
    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
